// File: rtl/fp_cmp_unit_pkg.sv
// Shared types and constants for the fp_exe compare/move responder.
package fp_cmp_wire;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned FLAGS_W   = 5;
    localparam int unsigned FCLASS_W  = 10;
    localparam int unsigned FLAG_NV   = 4;

    localparam logic [2:0] FCMP_FEQ   = 3'd2;
    localparam logic [2:0] FCMP_FLT   = 3'd1;
    localparam logic [2:0] FCMP_FLE   = 3'd0;
    localparam logic [2:0] FMV_FCLASS = 3'd1;

    localparam logic [1:0] FMT_S = 2'd0;
    localparam logic [1:0] FMT_D = 2'd1;

    // One bit per fp_exe operation; only fcmp and the raw moves are honoured here
    typedef struct packed {
        logic fmadd;
        logic fadd;
        logic fsub;
        logic fmul;
        logic fdiv;
        logic fsqrt;
        logic fcmp;
        logic fmv_i2f;
        logic fmv_f2i;
    } fp_operation_type;

    typedef struct packed {
        logic sign;
        logic zero;
        logic inf;
        logic nan;
        logic snan;
        logic subnorm;
    } fp_cmp_class_type;

    // KIND_NONE with valid set marks an unsupported request (zero response)
    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_CMP,
        KIND_I2F,
        KIND_F2I
    } fp_cmp_kind_type;

    typedef struct packed {
        logic             valid;
        fp_cmp_kind_type  kind;
        logic             is_f64;
        logic [2:0]       rm;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        fp_cmp_class_type cls_a;
        fp_cmp_class_type cls_b;
    } fp_cmp_stage_type;

    localparam fp_cmp_stage_type STAGE_INIT = '{
        valid:  1'b0,
        kind:   KIND_NONE,
        is_f64: 1'b0,
        rm:     3'd0,
        a:      '0,
        b:      '0,
        cls_a:  '0,
        cls_b:  '0
    };

endpackage

// File: rtl/fp_cmp_unit_if.sv
// fp_exe request/response bundle; master issues requests, slave responds.
interface fp_cmp_unit_if;
    import fp_cmp_wire::*;

    logic [XLEN-1:0]    data1;
    logic [XLEN-1:0]    data2;
    logic [XLEN-1:0]    data3;
    logic [1:0]         fmt;
    logic [2:0]         rm;
    fp_operation_type   op;
    logic               enable;
    logic [XLEN-1:0]    result;
    logic [FLAGS_W-1:0] flags;
    logic               ready;

    modport master (
        output data1, data2, data3, fmt, rm, op, enable,
        input  result, flags, ready
    );

    modport slave (
        input  data1, data2, data3, fmt, rm, op, enable,
        output result, flags, ready
    );

endinterface

// File: rtl/fp_cmp_class.sv
// Combinational operand classifier for f32 (NaN-boxed) and f64 encodings.
module fp_cmp_class
    import fp_cmp_wire::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      fmt,
    output fp_cmp_class_type cls
);

    logic is_f64;
    logic boxed;
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    logic quiet;

    always_comb begin
        is_f64   = (fmt == FMT_D);
        boxed    = &data[63:32];
        exp_ones = 1'b0;
        exp_zero = 1'b0;
        man_zero = 1'b0;
        quiet    = 1'b0;
        cls      = '0;
        if (is_f64) begin
            exp_ones = &data[62:52];
            exp_zero = ~|data[62:52];
            man_zero = ~|data[51:0];
            quiet    = data[51];
        end else begin
            exp_ones = &data[30:23];
            exp_zero = ~|data[30:23];
            man_zero = ~|data[22:0];
            quiet    = data[22];
        end
        // A badly boxed single reads as the canonical quiet NaN
        if (!is_f64 && !boxed) begin
            cls.nan = 1'b1;
        end else begin
            cls.sign    = is_f64 ? data[63] : data[31];
            cls.zero    = exp_zero & man_zero;
            cls.subnorm = exp_zero & ~man_zero;
            cls.inf     = exp_ones & man_zero;
            cls.nan     = exp_ones & ~man_zero;
            cls.snan    = exp_ones & ~man_zero & ~quiet;
        end
    end

endmodule

// File: rtl/fp_cmp_unit.sv
// Two-stage fp_exe responder for fcmp and raw moves; define FP_CMP_CLASS_EN
// to make fmv_f2i with rm=1 return the fclass one-hot instead.
module fp_cmp_unit
    import fp_cmp_wire::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic          clock,
    input  logic          reset,
    fp_cmp_unit_if.slave  bus
);

    if (LATENCY != 2) begin : g_bad_latency
        $error("fp_cmp_unit supports only LATENCY = 2");
    end

    fp_cmp_class_type cls_a;
    fp_cmp_class_type cls_b;
    fp_cmp_stage_type s1_d;
    fp_cmp_stage_type s1_q;

    logic [XLEN-1:0]    result_d;
    logic [XLEN-1:0]    result_q;
    logic [FLAGS_W-1:0] flags_d;
    logic [FLAGS_W-1:0] flags_q;
    logic               ready_q;

    fp_cmp_class u_class_a (.data(bus.data1), .fmt(bus.fmt), .cls(cls_a));
    fp_cmp_class u_class_b (.data(bus.data2), .fmt(bus.fmt), .cls(cls_b));

    // Stage 1: decode the request and capture operands with their classes
    always_comb begin
        s1_d        = STAGE_INIT;
        s1_d.valid  = bus.enable;
        s1_d.is_f64 = (bus.fmt == FMT_D);
        s1_d.rm     = bus.rm;
        s1_d.a      = bus.data1;
        s1_d.b      = bus.data2;
        s1_d.cls_a  = cls_a;
        s1_d.cls_b  = cls_b;
        if (bus.fmt == FMT_S || bus.fmt == FMT_D) begin
            case ({bus.op.fcmp, bus.op.fmv_i2f, bus.op.fmv_f2i})
                3'b100:  s1_d.kind = KIND_CMP;
                3'b010:  s1_d.kind = KIND_I2F;
                3'b001:  s1_d.kind = KIND_F2I;
                default: s1_d.kind = KIND_NONE;
            endcase
        end
    end

    logic [62:0] mag_a;
    logic [62:0] mag_b;
    logic        any_nan;
    logic        any_snan;
    logic        both_zero;
    logic        eq;
    logic        lt;
    logic [XLEN-1:0] move_f2i;

    // Sign-magnitude ordering; NaNs are unordered, zeros of either sign are equal
    always_comb begin
        mag_a     = s1_q.is_f64 ? s1_q.a[62:0] : 63'(s1_q.a[30:0]);
        mag_b     = s1_q.is_f64 ? s1_q.b[62:0] : 63'(s1_q.b[30:0]);
        any_nan   = s1_q.cls_a.nan | s1_q.cls_b.nan;
        any_snan  = s1_q.cls_a.snan | s1_q.cls_b.snan;
        both_zero = s1_q.cls_a.zero & s1_q.cls_b.zero;
        eq        = ~any_nan & (both_zero |
                    ((s1_q.cls_a.sign == s1_q.cls_b.sign) && (mag_a == mag_b)));
        if (any_nan || both_zero) begin
            lt = 1'b0;
        end else if (s1_q.cls_a.sign != s1_q.cls_b.sign) begin
            lt = s1_q.cls_a.sign;
        end else if (s1_q.cls_a.sign) begin
            lt = (mag_a > mag_b);
        end else begin
            lt = (mag_a < mag_b);
        end
        move_f2i = s1_q.is_f64 ? s1_q.a : {{32{s1_q.a[31]}}, s1_q.a[31:0]};
    end

`ifdef FP_CMP_CLASS_EN
    logic [FCLASS_W-1:0] fclass;
    logic                a_normal;

    always_comb begin
        a_normal  = ~(s1_q.cls_a.nan | s1_q.cls_a.inf | s1_q.cls_a.zero | s1_q.cls_a.subnorm);
        fclass    = '0;
        fclass[9] = s1_q.cls_a.nan & ~s1_q.cls_a.snan;
        fclass[8] = s1_q.cls_a.snan;
        fclass[7] = ~s1_q.cls_a.sign & s1_q.cls_a.inf;
        fclass[6] = ~s1_q.cls_a.sign & a_normal;
        fclass[5] = ~s1_q.cls_a.sign & s1_q.cls_a.subnorm;
        fclass[4] = ~s1_q.cls_a.sign & s1_q.cls_a.zero;
        fclass[3] =  s1_q.cls_a.sign & s1_q.cls_a.zero;
        fclass[2] =  s1_q.cls_a.sign & s1_q.cls_a.subnorm;
        fclass[1] =  s1_q.cls_a.sign & a_normal;
        fclass[0] =  s1_q.cls_a.sign & s1_q.cls_a.inf;
    end
`endif

    // Stage 2: response selection; idle and unsupported slots return zero
    always_comb begin
        result_d = '0;
        flags_d  = '0;
        if (s1_q.valid) begin
            case (s1_q.kind)
                KIND_CMP: begin
                    case (s1_q.rm)
                        FCMP_FEQ: begin
                            result_d          = XLEN'(eq);
                            flags_d[FLAG_NV]  = any_snan;
                        end
                        FCMP_FLT: begin
                            result_d          = XLEN'(lt);
                            flags_d[FLAG_NV]  = any_nan;
                        end
                        FCMP_FLE: begin
                            result_d          = XLEN'(lt | eq);
                            flags_d[FLAG_NV]  = any_nan;
                        end
                        default: ;
                    endcase
                end
                KIND_I2F: result_d = s1_q.is_f64 ? s1_q.a : {32'hFFFF_FFFF, s1_q.a[31:0]};
`ifdef FP_CMP_CLASS_EN
                KIND_F2I: result_d = (s1_q.rm == FMV_FCLASS) ? XLEN'(fclass) : move_f2i;
`else
                KIND_F2I: result_d = move_f2i;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q     <= STAGE_INIT;
            result_q <= '0;
            flags_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            ready_q  <= s1_q.valid;
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.ready  = ready_q;

    // data3 and the arithmetic op bits belong to the full datapath
    logic unused_bits;
    assign unused_bits = ^{bus.data3, bus.op, s1_q.cls_a, s1_q.cls_b};

endmodule

// File: tb/tb_fp_cmp_unit.sv
// Scoreboard bench for fp_cmp_unit: directed requests push expectations, a monitor checks responses.
module tb_fp_cmp_unit;
    import fp_cmp_wire::*;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic [4:0]  flg;
        int          cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_pass;
    int   n_total;
    logic end_req;
    logic end_done;
    exp_t exp_q[$];

    fp_cmp_unit_if bus ();

    fp_cmp_unit #(.LATENCY(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    localparam int OP_CMP = 0;
    localparam int OP_I2F = 1;
    localparam int OP_F2I = 2;
    localparam int OP_ADD = 3;
    localparam int OP_TWO = 4;

    function automatic fp_operation_type mk_op(input int k);
        fp_operation_type o;
        o = '0;
        case (k)
            OP_CMP:  o.fcmp    = 1'b1;
            OP_I2F:  o.fmv_i2f = 1'b1;
            OP_F2I:  o.fmv_f2i = 1'b1;
            OP_ADD:  o.fadd    = 1'b1;
            default: begin
                o.fcmp    = 1'b1;
                o.fmv_f2i = 1'b1;
            end
        endcase
        return o;
    endfunction

    task automatic send(input string name, input int k, input logic [1:0] fmt,
                        input logic [2:0] rm, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input logic [4:0] ef);
        exp_t e;
        @(posedge clock);
        #1;
        bus.enable = 1'b1;
        bus.op     = mk_op(k);
        bus.fmt    = fmt;
        bus.rm     = rm;
        bus.data1  = a;
        bus.data2  = b;
        bus.data3  = '0;
        e.name = name;
        e.res  = er;
        e.flg  = ef;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            bus.enable = 1'b0;
            bus.op     = '0;
        end
    endtask

    // Monitor: every cycle either a response matches the queue head or outputs are quiet
    always @(negedge clock) begin
        exp_t e;
        if (bus.ready === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_ready: cycle %0d result=%h flags=%b, expected no response",
                         cyc, bus.result, bus.flags);
            end else begin
                e = exp_q.pop_front();
                if (bus.result === e.res && bus.flags === e.flg && cyc == e.cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got result=%h flags=%b cycle=%0d, expected result=%h flags=%b cycle=%0d",
                             e.name, bus.result, bus.flags, cyc, e.res, e.flg, e.cyc);
                end
            end
        end else begin
            n_total++;
            if (bus.ready === 1'b0 && bus.result === 64'd0 && bus.flags === 5'd0) begin
                n_pass++;
            end else begin
                $display("FAIL idle_quiet: cycle %0d ready=%b result=%h flags=%b, expected 0/0/0",
                         cyc, bus.ready, bus.result, bus.flags);
            end
        end
        if (end_req === 1'b1 && !end_done) begin
            end_done = 1'b1;
            n_total++;
            if (exp_q.size() == 0) n_pass++;
            else $display("FAIL drain: %0d responses missing, expected 0", exp_q.size());
        end
    end

    logic [63:0] cls_ninf;
    logic [63:0] cls_snan;
    logic [63:0] cls_unbox;

    initial begin
        cyc        = 0;
        n_pass     = 0;
        n_total    = 0;
        end_req    = 1'b0;
        end_done   = 1'b0;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.op     = '0;
        bus.fmt    = '0;
        bus.rm     = '0;
        bus.data1  = '0;
        bus.data2  = '0;
        bus.data3  = '0;
`ifdef FP_CMP_CLASS_EN
        cls_ninf  = 64'h0000_0000_0000_0001;
        cls_snan  = 64'h0000_0000_0000_0100;
        cls_unbox = 64'h0000_0000_0000_0200;
`else
        cls_ninf  = 64'hFFFF_FFFF_FF80_0000;
        cls_snan  = 64'h0000_0000_7FA0_0000;
        cls_unbox = 64'h0000_0000_1234_5678;
`endif
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        idle(2);

        // Back-to-back mixed stream
        send("flt_s_1lt2",   OP_CMP, FMT_S, FCMP_FLT, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF40000000, 64'd1, 5'h00);
        send("flt_s_2lt1",   OP_CMP, FMT_S, FCMP_FLT, 64'hFFFFFFFF40000000, 64'hFFFFFFFF3F800000, 64'd0, 5'h00);
        send("feq_s_pz_nz",  OP_CMP, FMT_S, FCMP_FEQ, 64'hFFFFFFFF00000000, 64'hFFFFFFFF80000000, 64'd1, 5'h00);
        send("fle_d_qnan",   OP_CMP, FMT_D, FCMP_FLE, 64'h7FF8000000000000, 64'h3FF0000000000000, 64'd0, 5'h10);
        send("feq_s_snan",   OP_CMP, FMT_S, FCMP_FEQ, 64'hFFFFFFFF7FA00000, 64'hFFFFFFFF3F800000, 64'd0, 5'h10);
        send("feq_s_qnan",   OP_CMP, FMT_S, FCMP_FEQ, 64'hFFFFFFFF7FC00000, 64'hFFFFFFFF3F800000, 64'd0, 5'h00);
        send("feq_s_unbox",  OP_CMP, FMT_S, FCMP_FEQ, 64'h000000003F800000, 64'h000000003F800000, 64'd0, 5'h00);
        send("i2f_s",        OP_I2F, FMT_S, 3'd0,     64'h0000000012345678, 64'd0, 64'hFFFFFFFF12345678, 5'h00);
        idle(2);

        send("f2i_s_neg",    OP_F2I, FMT_S, 3'd0,     64'hFFFFFFFF80000001, 64'd0, 64'hFFFFFFFF80000001, 5'h00);
        send("f2i_s_nobox",  OP_F2I, FMT_S, 3'd0,     64'h0000000012345678, 64'd0, 64'h0000000012345678, 5'h00);
        send("f2i_d",        OP_F2I, FMT_D, 3'd0,     64'h0123456789ABCDEF, 64'd0, 64'h0123456789ABCDEF, 5'h00);
        send("i2f_d",        OP_I2F, FMT_D, 3'd0,     64'hFEDCBA9876543210, 64'd0, 64'hFEDCBA9876543210, 5'h00);
        send("flt_d_neg",    OP_CMP, FMT_D, FCMP_FLT, 64'hC000000000000000, 64'hBFF0000000000000, 64'd1, 5'h00);
        send("flt_d_negrev", OP_CMP, FMT_D, FCMP_FLT, 64'hBFF0000000000000, 64'hC000000000000000, 64'd0, 5'h00);
        send("fle_d_eq",     OP_CMP, FMT_D, FCMP_FLE, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'd1, 5'h00);
        send("feq_d_eq",     OP_CMP, FMT_D, FCMP_FEQ, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'd1, 5'h00);
        send("flt_s_zeros",  OP_CMP, FMT_S, FCMP_FLT, 64'hFFFFFFFF00000000, 64'hFFFFFFFF80000000, 64'd0, 5'h00);
        send("fle_s_zeros",  OP_CMP, FMT_S, FCMP_FLE, 64'hFFFFFFFF80000000, 64'hFFFFFFFF00000000, 64'd1, 5'h00);
        send("flt_s_neg_pos",OP_CMP, FMT_S, FCMP_FLT, 64'hFFFFFFFFBF800000, 64'hFFFFFFFF3F800000, 64'd1, 5'h00);
        send("flt_s_snan",   OP_CMP, FMT_S, FCMP_FLT, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF7FA00000, 64'd0, 5'h10);
        idle(1);

        // Unsupported and reserved encodings
        send("fcmp_rm3",     OP_CMP, FMT_S, 3'd3,     64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 64'd0, 5'h00);
        send("bad_fmt",      OP_CMP, 2'd2,  FCMP_FEQ, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'd0, 5'h00);
        send("two_ops",      OP_TWO, FMT_D, FCMP_FEQ, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'd0, 5'h00);
        send("no_op",        OP_ADD, FMT_D, 3'd0,     64'h3FF0000000000000, 64'h3FF0000000000000, 64'd0, 5'h00);

        // fmv_f2i with rm=1: fclass when enabled, plain move otherwise
        send("f2i_rm1_ninf", OP_F2I, FMT_S, FMV_FCLASS, 64'hFFFFFFFFFF800000, 64'd0, cls_ninf, 5'h00);
        send("f2i_rm1_snan", OP_F2I, FMT_S, FMV_FCLASS, 64'hFFFFFFFF7FA00000, 64'd0, cls_snan, 5'h00);
        send("f2i_rm1_unbx", OP_F2I, FMT_S, FMV_FCLASS, 64'h0000000012345678, 64'd0, cls_unbox, 5'h00);
        idle(4);

        // Reset one cycle after the third request drops the third in flight
        send("rst_req1",     OP_CMP, FMT_S, FCMP_FLT, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF40000000, 64'd1, 5'h00);
        send("rst_req2",     OP_I2F, FMT_S, 3'd0,     64'h00000000CAFEF00D, 64'd0, 64'hFFFFFFFFCAFEF00D, 5'h00);
        send("rst_req3",     OP_CMP, FMT_S, FCMP_FEQ, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 64'd1, 5'h00);
        @(posedge clock);
        #1;
        bus.enable = 1'b0;
        bus.op     = '0;
        reset      = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clock);
        #1 reset = 1'b0;
        idle(3);
        send("post_reset",   OP_CMP, FMT_D, FCMP_FLE, 64'hC000000000000000, 64'h3FF0000000000000, 64'd1, 5'h00);
        idle(6);

        end_req = 1'b1;
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
